// File: rtl/saber_pkg.sv
// saber_pkg: shared polynomial sizes, coefficient widths, words per polynomial and FSM encoding
package saber_pkg;
   localparam int N       = 256;
   localparam int Q_BITS  = 13;
   localparam int P_BITS  = 10;
   localparam int WORDS_Q = N * Q_BITS / 64;
   localparam int WORDS_P = N * P_BITS / 64;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/poly_result_packer_if.sv
// poly_result_packer_if: coefficient input stream, packed word output stream and run status
interface poly_result_packer_if;
   logic        start;
   logic [63:0] coeff4x_in;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [5:0]  out_addr;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   modport slave (input start, coeff4x_in, in_valid, out_ready,
                  output in_ready, out_data, out_addr, out_valid, busy, done);
   modport master (output start, coeff4x_in, in_valid, out_ready,
                   input in_ready, out_data, out_addr, out_valid, busy, done);
endinterface

// File: rtl/poly_result_packer_bitbuf.sv
// pack_bitbuf: bit buffer that appends four CW-bit coefficients at the fill point and pops 64-bit words
module pack_bitbuf #(
   parameter int CW = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_push,
   input  logic [63:0] i_coeff,
   input  logic        i_pop,
   output logic [63:0] o_word,
   output logic [6:0]  o_fill
);
   localparam int W = 64 + 4 * CW - 1;
   logic [W-1:0]    r_buf;
   logic [6:0]      r_fill;
   logic [4*CW-1:0] w_lanes;
   logic [W-1:0]    w_app;
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_lanes[k*CW +: CW] = CW'(i_coeff[16*k +: 16]);
   end
   assign w_app  = {{(W-4*CW){1'b0}}, w_lanes} << r_fill;
   assign o_word = r_buf[63:0];
   assign o_fill = r_fill;
   // append at the fill point on push, drop the low word on pop; the two never coincide
   always_ff @(posedge clk) begin
      if (!rst || i_clr) begin
         r_buf  <= '0;
         r_fill <= '0;
      end else if (i_push) begin
         r_buf  <= r_buf | w_app;
         r_fill <= r_fill + 7'(4 * CW);
      end else if (i_pop) begin
         r_buf  <= r_buf >> 64;
         r_fill <= r_fill - 7'd64;
      end
   end
endmodule

// File: rtl/poly_result_packer.sv
// poly_result_packer: packs 256 coefficients into CW-bit fields of 64-bit words; PACKER_MODP_EN selects CW=10
module poly_result_packer
   import saber_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   poly_result_packer_if.slave bus
);
`ifdef PACKER_MODP_EN
   localparam int CW    = P_BITS;
   localparam int WORDS = WORDS_P;
`else
   localparam int CW    = Q_BITS;
   localparam int WORDS = WORDS_Q;
`endif
   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic [6:0]  r_beats;
   logic [5:0]  r_addr;
   logic [6:0]  w_fill;
   logic [63:0] w_word;
   logic        w_push;
   logic        w_pop;
   logic        w_last;
   assign bus.in_ready  = r_state == ST_RUN && w_fill < 7'd64 && r_beats < 7'd64;
   assign bus.out_valid = r_state == ST_RUN && w_fill >= 7'd64;
   assign bus.out_data  = w_word;
   assign bus.out_addr  = r_addr;
   assign bus.busy      = r_state != ST_IDLE;
   assign bus.done      = r_state == ST_DONE;
   assign w_push = bus.in_ready && bus.in_valid;
   assign w_pop  = bus.out_valid && bus.out_ready;
   assign w_last = w_pop && r_addr == 6'(WORDS - 1);
   // next state: start only honoured in IDLE, DONE lasts a single cycle
   always_comb begin
      w_next = r_state == ST_IDLE ? (bus.start ? ST_RUN : ST_IDLE) :
               r_state == ST_RUN  ? (w_last ? ST_DONE : ST_RUN) : ST_IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      r_state <= !rst ? ST_IDLE : w_next;
   end
   // beat and word counters live only while running, so every run starts from address 0
   always_ff @(posedge clk) begin
      if (!rst || r_state != ST_RUN) begin
         r_beats <= '0;
         r_addr  <= '0;
      end else begin
         if (w_push) r_beats <= r_beats + 7'd1;
         if (w_pop)  r_addr  <= r_addr + 6'd1;
      end
   end
   pack_bitbuf #(.CW(CW)) u_bitbuf (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (r_state != ST_RUN),
      .i_push (w_push),
      .i_coeff(bus.coeff4x_in),
      .i_pop  (w_pop),
      .o_word (w_word),
      .o_fill (w_fill)
   );
endmodule

// File: tb/tb_poly_result_packer.sv
// tb_poly_result_packer: scoreboard bench for poly_result_packer; honours PACKER_MODP_EN
module tb_poly_result_packer;
   import saber_pkg::*;
`ifdef PACKER_MODP_EN
   localparam int CW    = P_BITS;
   localparam int WORDS = WORDS_P;
`else
   localparam int CW    = Q_BITS;
   localparam int WORDS = WORDS_Q;
`endif
   typedef struct {
      logic [63:0] data;
      logic [5:0]  addr;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   logic        stream [0:4095];
   int          nbits;
   int          pushed;
   logic [63:0] first_word;
   poly_result_packer_if bus();
   poly_result_packer dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " in_ready"},  64'(bus.in_ready),  64'd0);
      check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, " out_data"},  bus.out_data,       64'd0);
      check({tag, " out_addr"},  64'(bus.out_addr),  64'd0);
      check({tag, " busy"},      64'(bus.busy),      64'd0);
      check({tag, " done"},      64'(bus.done),      64'd0);
   endtask

   function automatic logic [63:0] beat_data(input int mode, input int beat);
      logic [63:0] d;
      for (int k = 0; k < 4; k++)
         d[16*k +: 16] = mode == 0 ? 16'h1FFF : mode == 1 ? 16'(4 * beat + k) :
                         mode == 2 ? 16'hE001 : mode == 3 ? 16'($urandom) : 16'h03FF;
      return d;
   endfunction

   // reference: lay every coefficient's low CW bits into a flat bit stream, cut words every 64 bits
   task automatic model_beat(input logic [63:0] d);
      exp_t e;
      for (int k = 0; k < 4; k++)
         for (int b = 0; b < CW; b++) begin
            stream[nbits] = d[16*k + b];
            nbits++;
         end
      while (nbits >= 64 * (pushed + 1)) begin
         for (int j = 0; j < 64; j++) e.data[j] = stream[64*pushed + j];
         e.addr = 6'(pushed);
         sb.push_back(e);
         pushed++;
      end
   endtask

   task automatic run(input string tag, input int mode, input int stall_at, input int abort_at, input bit spam);
      int          beat = 0;
      int          got = 0;
      int          cyc = 0;
      int          stall = 0;
      bit          fin = 0;
      bit          stalled = 0;
      logic [63:0] cur;
      logic [63:0] hold_d = '0;
      logic [5:0]  hold_a = '0;
      exp_t        e;
      nbits = 0;
      pushed = 0;
      sb.delete();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cur = beat_data(mode, 0);
      while (!fin && cyc < 2000) begin
         if (!stalled && stall_at >= 0 && bus.out_valid && bus.out_addr == 6'(stall_at)) begin
            stalled = 1;
            stall = 10;
            hold_d = bus.out_data;
            hold_a = bus.out_addr;
         end
         if (abort_at >= 0 && beat == abort_at) begin
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            rst = 1'b0;
            @(negedge clk);
            #1;
            check_zero({tag, " reset"});
            rst = 1'b1;
            repeat (5) begin
               @(negedge clk);
               #1;
               check({tag, " no out_valid after reset"}, 64'(bus.out_valid), 64'd0);
            end
            return;
         end
         bus.in_valid   = beat < 64;
         bus.coeff4x_in = cur;
         bus.out_ready  = stall == 0;
         bus.start      = spam && cyc % 7 == 3;
         #1;
         if (stall > 0) begin
            check({tag, " stall in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, " stall out_data"}, bus.out_data, hold_d);
            check({tag, " stall out_addr"}, 64'(bus.out_addr), 64'(hold_a));
            stall--;
         end
         if (bus.in_valid && bus.in_ready) begin
            model_beat(cur);
            beat++;
            cur = beat_data(mode, beat);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check({tag, " unexpected word addr"}, 64'(bus.out_addr), 64'hFFFF);
            end else begin
               e = sb.pop_front();
               check({tag, " out_data"}, bus.out_data, e.data);
               check({tag, " out_addr"}, 64'(bus.out_addr), 64'(e.addr));
            end
            if (got == 0) first_word = bus.out_data;
            got++;
            fin = got == WORDS;
         end
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check({tag, " completed within budget"}, 64'(fin), 64'd1);
      check({tag, " word count"}, 64'(got), 64'(WORDS));
      check({tag, " scoreboard drained"}, 64'(sb.size()), 64'd0);
      #1;
      check({tag, " done pulse"}, 64'(bus.done), 64'd1);
      check({tag, " busy in done"}, 64'(bus.busy), 64'd1);
      @(negedge clk);
      #1;
      check({tag, " done cleared"}, 64'(bus.done), 64'd0);
      check({tag, " busy cleared"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.coeff4x_in = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_zero("por");
      rst = 1'b1;
      run("ones", 0, -1, -1, 0);
      check("ones word0", first_word, 64'hFFFF_FFFF_FFFF_FFFF);
      run("index", 1, -1, -1, 0);
`ifdef PACKER_MODP_EN
      check("index word0", first_word, 64'h6014_0400_C020_0400);
`else
      check("index word0", first_word, 64'h0040_0180_0800_2000);
`endif
      run("e001", 2, -1, -1, 0);
`ifdef PACKER_MODP_EN
      check("e001 word0", first_word, 64'h1004_0100_4010_0401);
`else
      check("e001 word0", first_word, 64'h0010_0080_0400_2001);
`endif
      run("stall", 1, 20, -1, 0);
      run("abort", 1, -1, 20, 0);
      run("restart", 1, -1, -1, 1);
      run("random", 3, -1, -1, 0);
`ifdef PACKER_MODP_EN
      run("modp", 4, -1, -1, 0);
      check("modp word0", first_word, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
